// File: rtl/motor_pwm_driver_pkg.sv
// Shared definitions for the motor PWM driver: direction codes and channel state encoding.
package motor_pwm_driver_pkg;

  localparam logic [1:0] DIR_COAST = 2'b00;
  localparam logic [1:0] DIR_REV   = 2'b01;
  localparam logic [1:0] DIR_FWD   = 2'b10;
  localparam logic [1:0] DIR_BRAKE = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RAMP,
    RUN,
    DEAD,
    BRAKE
  } chan_state_t;

endpackage

// File: rtl/motor_channel.sv
// One H-bridge channel: direction FSM, soft-start duty ramp and reversal dead time.
// All outputs are registered from next-state values, so a command shows on the pins one clock later.
module motor_channel
  import motor_pwm_driver_pkg::*;
#(
  parameter int PWM_PERIOD = 1000,
  parameter int DUTY_W     = 10,
  parameter int RAMP_STEP  = 10,
  parameter int RAMP_DIV   = 100,
  parameter int DEADTIME   = 50
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        code,
  input  logic              enable,
  input  logic [DUTY_W-1:0] duty_target,
  input  logic [DUTY_W-1:0] pwm_cnt,
  output logic [1:0]        hb,
  output logic              pwm,
  output logic [DUTY_W-1:0] duty,
  output logic              in_deadtime
);

  localparam int PRE_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DEAD_W = $clog2(DEADTIME + 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(RAMP_DIV - 1);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEADTIME);
  localparam logic [DUTY_W:0]   STEP      = (DUTY_W + 1)'(RAMP_STEP);

  chan_state_t       state_q, state_d;
  logic [1:0]        dir_q, dir_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [DEAD_W-1:0] dcnt_q, dcnt_d;
  logic [DUTY_W:0]   duty_sum;
  logic [1:0]        hb_d;
  logic              pwm_d;

  // Coast/disable and brake override everything; the per-state cases only see active fwd/rev codes.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    duty_d   = duty_q;
    pre_d    = pre_q;
    dcnt_d   = dcnt_q;
    duty_sum = {1'b0, duty_q} + STEP;
    if (!enable || code == DIR_COAST) begin
      state_d = IDLE;
      duty_d  = '0;
    end else if (code == DIR_BRAKE) begin
      state_d = BRAKE;
      duty_d  = '0;
    end else begin
      case (state_q)
        IDLE, BRAKE: begin
          state_d = RAMP;
          dir_d   = code;
          duty_d  = '0;
          pre_d   = '0;
        end
        RAMP: begin
          if (code != dir_q) begin
            state_d = DEAD;
            duty_d  = '0;
            dcnt_d  = DEAD_LOAD;
          end else if (duty_q >= duty_target) begin
            state_d = RUN;
            duty_d  = duty_target;
          end else if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (duty_sum >= {1'b0, duty_target}) begin
              state_d = RUN;
              duty_d  = duty_target;
            end else begin
              duty_d = duty_sum[DUTY_W-1:0];
            end
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
        RUN: begin
          if (code != dir_q) begin
            state_d = DEAD;
            duty_d  = '0;
            dcnt_d  = DEAD_LOAD;
          end else if (duty_target > duty_q) begin
            state_d = RAMP;
            pre_d   = '0;
          end else begin
            duty_d = duty_target;
          end
        end
        DEAD: begin
          // The full interval always runs, even if the command returns to the old direction.
          if (dcnt_q <= DEAD_W'(1)) begin
            state_d = RAMP;
            dir_d   = code;
            duty_d  = '0;
            pre_d   = '0;
          end else begin
            dcnt_d = dcnt_q - DEAD_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          duty_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    hb_d  = 2'b00;
    pwm_d = 1'b0;
    case (state_d)
      RAMP, RUN: begin
        hb_d  = dir_d;
        pwm_d = (pwm_cnt < duty_q);
      end
      BRAKE: begin
        hb_d  = 2'b11;
        pwm_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dir_q       <= DIR_COAST;
      duty_q      <= '0;
      pre_q       <= '0;
      dcnt_q      <= '0;
      hb          <= 2'b00;
      pwm         <= 1'b0;
      in_deadtime <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      duty_q      <= duty_d;
      pre_q       <= pre_d;
      dcnt_q      <= dcnt_d;
      hb          <= hb_d;
      pwm         <= pwm_d;
      in_deadtime <= (state_d == DEAD);
    end
  end

  assign duty = duty_q;

endmodule

// File: rtl/motor_pwm_driver.sv
// Two-channel H-bridge PWM driver with shared PWM counter and duty clamp.
// Define INPUT_SYNC_EN to pass motorL/motorR/enableAB through a two-flop synchroniser.
module motor_pwm_driver
  import motor_pwm_driver_pkg::*;
#(
  parameter int PWM_PERIOD = 1000,
  parameter int DUTY_W     = 10,
  parameter int RAMP_STEP  = 10,
  parameter int RAMP_DIV   = 100,
  parameter int DEADTIME   = 50
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [1:0]        motorL,
  input  logic [1:0]        motorR,
  input  logic [1:0]        enableAB,
  input  logic [DUTY_W-1:0] duty_target,
  output logic [1:0]        hbL,
  output logic [1:0]        hbR,
  output logic              pwmA,
  output logic              pwmB,
  output logic [DUTY_W-1:0] dutyL,
  output logic [DUTY_W-1:0] dutyR,
  output logic [1:0]        in_deadtime
);

  localparam logic [DUTY_W-1:0] PERIOD    = DUTY_W'(PWM_PERIOD);
  localparam logic [DUTY_W-1:0] CNT_LAST  = DUTY_W'(PWM_PERIOD - 1);

  logic [DUTY_W-1:0] cnt_q;
  logic [DUTY_W-1:0] target_c;
  logic [1:0]        ml_s, mr_s, en_s;

`ifdef INPUT_SYNC_EN
  logic [5:0] sync1_q, sync2_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {enableAB, motorR, motorL};
      sync2_q <= sync1_q;
    end
  end

  assign {en_s, mr_s, ml_s} = sync2_q;
`else
  assign ml_s = motorL;
  assign mr_s = motorR;
  assign en_s = enableAB;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                cnt_q <= '0;
    else if (cnt_q == CNT_LAST) cnt_q <= '0;
    else                        cnt_q <= cnt_q + DUTY_W'(1);
  end

  assign target_c = (duty_target > PERIOD) ? PERIOD : duty_target;

  motor_channel #(
    .PWM_PERIOD(PWM_PERIOD), .DUTY_W(DUTY_W), .RAMP_STEP(RAMP_STEP),
    .RAMP_DIV(RAMP_DIV), .DEADTIME(DEADTIME)
  ) u_left (
    .clk(CLK), .rst_n(RST_N), .code(ml_s), .enable(en_s[0]),
    .duty_target(target_c), .pwm_cnt(cnt_q),
    .hb(hbL), .pwm(pwmA), .duty(dutyL), .in_deadtime(in_deadtime[0])
  );

  motor_channel #(
    .PWM_PERIOD(PWM_PERIOD), .DUTY_W(DUTY_W), .RAMP_STEP(RAMP_STEP),
    .RAMP_DIV(RAMP_DIV), .DEADTIME(DEADTIME)
  ) u_right (
    .clk(CLK), .rst_n(RST_N), .code(mr_s), .enable(en_s[1]),
    .duty_target(target_c), .pwm_cnt(cnt_q),
    .hb(hbR), .pwm(pwmB), .duty(dutyR), .in_deadtime(in_deadtime[1])
  );

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed testbench for motor_pwm_driver with PWM_PERIOD=20, RAMP_STEP=5, RAMP_DIV=4, DEADTIME=8.
module tb_motor_pwm_driver;

`ifdef INPUT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       CLK;
  logic       RST_N;
  logic [1:0] motorL, motorR, enableAB;
  logic [9:0] duty_target;
  logic [1:0] hbL, hbR, in_deadtime;
  logic       pwmA, pwmB;
  logic [9:0] dutyL, dutyR;

  int checks;
  int fails;

  motor_pwm_driver #(
    .PWM_PERIOD(20), .DUTY_W(10), .RAMP_STEP(5), .RAMP_DIV(4), .DEADTIME(8)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .motorL(motorL), .motorR(motorR),
    .enableAB(enableAB), .duty_target(duty_target),
    .hbL(hbL), .hbR(hbR), .pwmA(pwmA), .pwmB(pwmB),
    .dutyL(dutyL), .dutyR(dutyR), .in_deadtime(in_deadtime)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic test_reset;
    RST_N = 1'b0; motorL = 2'b00; motorR = 2'b00; enableAB = 2'b00; duty_target = 10'd20;
    #1;
    checks++;
    if ({hbL, hbR, pwmA, pwmB, dutyL, dutyR, in_deadtime} !== 26'd0) begin
      fails++;
      $display("[TB] FAIL reset_values: got %h required 0",
               {hbL, hbR, pwmA, pwmB, dutyL, dutyR, in_deadtime});
    end
    step(3);
    RST_N = 1'b1;
    step(4);
    checks++;
    if ({hbL, hbR, pwmA, pwmB, dutyL, dutyR, in_deadtime} !== 26'd0) begin
      fails++;
      $display("[TB] FAIL idle_after_reset: got %h required 0",
               {hbL, hbR, pwmA, pwmB, dutyL, dutyR, in_deadtime});
    end
  endtask

  task automatic test_soft_start;
    enableAB = 2'b11; motorL = 2'b10; motorR = 2'b10;
    step(LAT);
    checks++;
    if ({hbL, hbR} !== 4'b1010 || dutyL !== 10'd0) begin
      fails++;
      $display("[TB] FAIL start_pins: got hbL=%b hbR=%b dutyL=%0d required 10 10 0", hbL, hbR, dutyL);
    end
    for (int k = 1; k <= 4; k++) begin
      step(4);
      checks++;
      if (dutyL !== 10'(5 * k) || dutyR !== 10'(5 * k)) begin
        fails++;
        $display("[TB] FAIL ramp_step%0d: got L=%0d R=%0d required %0d", k, dutyL, dutyR, 5 * k);
      end
    end
    step(1);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({pwmA, pwmB} !== 2'b11 || dutyL !== 10'd20) begin
        fails++;
        $display("[TB] FAIL full_duty_c%0d: got pwmA=%b pwmB=%b dutyL=%0d required 1 1 20",
                 i, pwmA, pwmB, dutyL);
      end
      step(1);
    end
  endtask

  task automatic test_reversal;
    motorL = 2'b01;
    step(LAT);
    checks++;
    if (hbL !== 2'b00 || pwmA !== 1'b0 || dutyL !== 10'd0 || in_deadtime !== 2'b01) begin
      fails++;
      $display("[TB] FAIL dead_entry: got hbL=%b pwmA=%b dutyL=%0d dt=%b required 00 0 0 01",
               hbL, pwmA, dutyL, in_deadtime);
    end
    checks++;
    if (hbR !== 2'b10 || dutyR !== 10'd20 || pwmB !== 1'b1) begin
      fails++;
      $display("[TB] FAIL right_unaffected: got hbR=%b dutyR=%0d pwmB=%b required 10 20 1",
               hbR, dutyR, pwmB);
    end
    for (int i = 2; i <= 8; i++) begin
      step(1);
      checks++;
      if (in_deadtime[0] !== 1'b1 || hbL !== 2'b00) begin
        fails++;
        $display("[TB] FAIL dead_hold_c%0d: got dt=%b hbL=%b required 1 00", i, in_deadtime[0], hbL);
      end
    end
    step(1);
    checks++;
    if (hbL !== 2'b01 || in_deadtime !== 2'b00 || dutyL !== 10'd0) begin
      fails++;
      $display("[TB] FAIL dead_exit: got hbL=%b dt=%b dutyL=%0d required 01 00 0", hbL, in_deadtime, dutyL);
    end
    step(4);
    checks++;
    if (dutyL !== 10'd5) begin
      fails++;
      $display("[TB] FAIL reramp_first: got %0d required 5", dutyL);
    end
    step(12);
    checks++;
    if (dutyL !== 10'd20) begin
      fails++;
      $display("[TB] FAIL reramp_done: got %0d required 20", dutyL);
    end
  endtask

  task automatic test_brake_coast;
    motorR = 2'b11;
    step(LAT);
    checks++;
    if (hbR !== 2'b11 || pwmB !== 1'b1 || dutyR !== 10'd0) begin
      fails++;
      $display("[TB] FAIL brake: got hbR=%b pwmB=%b dutyR=%0d required 11 1 0", hbR, pwmB, dutyR);
    end
    motorR = 2'b10;
    step(LAT);
    checks++;
    if (hbR !== 2'b10 || in_deadtime[1] !== 1'b0 || dutyR !== 10'd0) begin
      fails++;
      $display("[TB] FAIL brake_to_ramp: got hbR=%b dt=%b dutyR=%0d required 10 0 0",
               hbR, in_deadtime[1], dutyR);
    end
    step(4);
    checks++;
    if (dutyR !== 10'd5) begin
      fails++;
      $display("[TB] FAIL brake_ramp_tick: got %0d required 5", dutyR);
    end
    motorR = 2'b00;
    step(LAT);
    checks++;
    if (hbR !== 2'b00 || pwmB !== 1'b0 || dutyR !== 10'd0) begin
      fails++;
      $display("[TB] FAIL coast: got hbR=%b pwmB=%b dutyR=%0d required 00 0 0", hbR, pwmB, dutyR);
    end
  endtask

  task automatic test_pwm_shape;
    logic prev;
    bit   found;
    duty_target = 10'd5;
    step(LAT);
    checks++;
    if (dutyL !== 10'd5) begin
      fails++;
      $display("[TB] FAIL duty_track_down: got %0d required 5", dutyL);
    end
    found = 1'b0;
    prev  = pwmA;
    for (int i = 0; i < 25 && !found; i++) begin
      step(1);
      if (prev === 1'b0 && pwmA === 1'b1) found = 1'b1;
      else prev = pwmA;
    end
    checks++;
    if (!found) begin
      fails++;
      $display("[TB] FAIL pwm_rise: got no rising edge in 25 cycles required one");
    end else begin
      for (int i = 0; i < 20; i++) begin
        checks++;
        if (pwmA !== (i < 5)) begin
          fails++;
          $display("[TB] FAIL pwm_shape_c%0d: got %b required %b", i, pwmA, (i < 5));
        end
        step(1);
      end
    end
    duty_target = 10'd15;
    step(LAT);
    checks++;
    if (dutyL !== 10'd5) begin
      fails++;
      $display("[TB] FAIL raise_hold: got %0d required 5", dutyL);
    end
    step(4);
    checks++;
    if (dutyL !== 10'd10) begin
      fails++;
      $display("[TB] FAIL raise_tick1: got %0d required 10", dutyL);
    end
    step(4);
    checks++;
    if (dutyL !== 10'd15) begin
      fails++;
      $display("[TB] FAIL raise_tick2: got %0d required 15", dutyL);
    end
    duty_target = 10'd25;
    step(LAT + 4);
    checks++;
    if (dutyL !== 10'd20) begin
      fails++;
      $display("[TB] FAIL clamp_tick: got %0d required 20", dutyL);
    end
    step(8);
    checks++;
    if (dutyL !== 10'd20 || pwmA !== 1'b1) begin
      fails++;
      $display("[TB] FAIL clamp_hold: got duty=%0d pwm=%b required 20 1", dutyL, pwmA);
    end
    duty_target = 10'd20;
  endtask

  task automatic test_abort;
    motorL = 2'b10;
    step(LAT);
    checks++;
    if (in_deadtime[0] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL abort_dead_entry: got %b required 1", in_deadtime[0]);
    end
    step(2);
    enableAB = 2'b10;
    step(LAT);
    checks++;
    if (in_deadtime[0] !== 1'b0 || hbL !== 2'b00 || pwmA !== 1'b0 || dutyL !== 10'd0) begin
      fails++;
      $display("[TB] FAIL abort_idle: got dt=%b hbL=%b pwmA=%b dutyL=%0d required 0 00 0 0",
               in_deadtime[0], hbL, pwmA, dutyL);
    end
    motorL = 2'b01; enableAB = 2'b11;
    step(LAT);
    checks++;
    if (hbL !== 2'b01 || in_deadtime[0] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL abort_reenable: got hbL=%b dt=%b required 01 0", hbL, in_deadtime[0]);
    end
    step(4);
    checks++;
    if (dutyL !== 10'd5) begin
      fails++;
      $display("[TB] FAIL abort_ramp: got %0d required 5", dutyL);
    end
  endtask

  task automatic test_reset_midrun;
    step(12);
    checks++;
    if (dutyL !== 10'd20 || hbL !== 2'b01) begin
      fails++;
      $display("[TB] FAIL pre_reset_run: got duty=%0d hbL=%b required 20 01", dutyL, hbL);
    end
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({hbL, hbR, pwmA, pwmB, dutyL, dutyR, in_deadtime} !== 26'd0) begin
      fails++;
      $display("[TB] FAIL async_reset: got %h required 0",
               {hbL, hbR, pwmA, pwmB, dutyL, dutyR, in_deadtime});
    end
    motorL = 2'b00; motorR = 2'b00;
    step(2);
    RST_N = 1'b1;
    step(5);
    checks++;
    if ({hbL, hbR, pwmA, pwmB, dutyL, dutyR, in_deadtime} !== 26'd0) begin
      fails++;
      $display("[TB] FAIL post_reset_idle: got %h required 0",
               {hbL, hbR, pwmA, pwmB, dutyL, dutyR, in_deadtime});
    end
    motorL = 2'b10;
    step(LAT);
    checks++;
    if (hbL !== 2'b10 || hbR !== 2'b00) begin
      fails++;
      $display("[TB] FAIL post_reset_cmd: got hbL=%b hbR=%b required 10 00", hbL, hbR);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset;
    test_soft_start;
    test_reversal;
    test_brake_coast;
    test_pwm_shape;
    test_abort;
    test_reset_midrun;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
